// File: rtl/quad_7seg_capture.sv
// Receive side of an 11-bit multiplexed 7-segment bus: samples the scanned
// display, rebuilds the 16-bit value and flags enable/pattern/order/stall faults.
module quad_7seg_capture #(
  parameter int unsigned HEX_MODE       = 1,
  parameter int unsigned STABLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] segDrivers,
  output logic [15:0] number,
  output logic        numberValid,
  output logic        locked,
  output logic        enErr,
  output logic        segErr,
  output logic        seqErr,
  output logic        timeout
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 2);
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {SYNC, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [10:0]     r_q, prev_q;
  logic [SW-1:0]   stable_q, stable_d;
  logic            captured_q, captured_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [1:0]      expect_q, expect_d;
  logic [3:0][3:0] nib_q, nib_d;
  logic [15:0]     number_q, number_d;
  logic            valid_q, valid_d, locked_q, locked_d;
  logic            en_err_q, en_err_d, seg_err_q, seg_err_d;
  logic            seq_err_q, seq_err_d, timeout_q, timeout_d;

  logic [6:0] seg;
  logic [3:0] val, en;
  logic [1:0] idx;
  logic       seg_ok, one_hot, multi_hot, visit_done, capture, timeout_hit;

  always_comb begin
    seg    = ~r_q[6:0];
    val    = 4'h0;
    seg_ok = 1'b1;
    case (seg)
      7'h7E: val = 4'h0;
      7'h30: val = 4'h1;
      7'h6D: val = 4'h2;
      7'h79: val = 4'h3;
      7'h33: val = 4'h4;
      7'h5B: val = 4'h5;
      7'h5F: val = 4'h6;
      7'h70: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h7B: val = 4'h9;
      7'h77: val = 4'hA;
      7'h1F: val = 4'hB;
      7'h4E: val = 4'hC;
      7'h3D: val = 4'hD;
      7'h4F: val = 4'hE;
      7'h47: val = 4'hF;
      default: seg_ok = 1'b0;
    endcase
    if (HEX_MODE == 0 && val >= 4'd10) seg_ok = 1'b0;

    en      = r_q[10:7];
    idx     = 2'd0;
    one_hot = 1'b1;
    case (en)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
    multi_hot = !one_hot && (en != 4'b0000);

    // Count is for the sample now in r_q, so STABLE_CYCLES=1 captures on first sight.
    if (en == 4'b0000)
      stable_d = '0;
    else if (r_q != prev_q)
      stable_d = SW'(1);
    else if (stable_q != SW'(STABLE_CYCLES + 1))
      stable_d = stable_q + SW'(1);
    else
      stable_d = stable_q;

    visit_done  = (en != prev_q[10:7]) ? 1'b0 : captured_q;
    capture     = one_hot && (stable_d == SW'(STABLE_CYCLES)) && !visit_done;
    captured_d  = visit_done | capture;
    timeout_hit = !capture && ((idle_q + IW'(1)) == IW'(TIMEOUT_CYCLES));
    idle_d      = (capture || timeout_hit) ? '0 : idle_q + IW'(1);
  end

  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    nib_d     = nib_q;
    number_d  = number_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    en_err_d  = 1'b0;
    seg_err_d = 1'b0;
    seq_err_d = 1'b0;
    timeout_d = 1'b0;

    if (multi_hot) begin
      en_err_d = 1'b1;
      state_d  = SYNC;
      locked_d = 1'b0;
    end else if (capture && !seg_ok) begin
      seg_err_d = 1'b1;
      state_d   = SYNC;
      locked_d  = 1'b0;
    end else if (capture) begin
      if (state_q == SYNC) begin
        if (idx == 2'd0) begin
          nib_d[0] = val;
          state_d  = COLLECT;
          expect_d = 2'd1;
        end
      end else if (idx == expect_q) begin
        nib_d[idx] = val;
        expect_d   = expect_q + 2'd1;
        if (idx == 2'd3) begin
          number_d = {val, nib_q[2], nib_q[1], nib_q[0]};
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
      end else begin
        seq_err_d = 1'b1;
        locked_d  = 1'b0;
        state_d   = SYNC;
        if (idx == 2'd0) begin
          nib_d[0] = val;
          state_d  = COLLECT;
          expect_d = 2'd1;
        end
      end
    end else if (timeout_hit) begin
      timeout_d = 1'b1;
      state_d   = SYNC;
      locked_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      r_q        <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      captured_q <= 1'b0;
      idle_q     <= '0;
      expect_q   <= '0;
      nib_q      <= '0;
      number_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      en_err_q   <= 1'b0;
      seg_err_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= segDrivers;
      prev_q     <= r_q;
      stable_q   <= stable_d;
      captured_q <= captured_d;
      idle_q     <= idle_d;
      expect_q   <= expect_d;
      nib_q      <= nib_d;
      number_q   <= number_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      en_err_q   <= en_err_d;
      seg_err_q  <= seg_err_d;
      seq_err_q  <= seq_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign number      = number_q;
  assign numberValid = valid_q;
  assign locked      = locked_q;
  assign enErr       = en_err_q;
  assign segErr      = seg_err_q;
  assign seqErr      = seq_err_q;
  assign timeout     = timeout_q;

endmodule
